// File: rtl/seq_booth_mul.sv
// Multi-cycle radix-2 Booth multiplier, runtime signed/unsigned, valid/ready on both sides.
// Define MUL_ACC_EN to add a wrapping product accumulator (acc_clr / acc_out ports).
module seq_booth_mul #(
   parameter int WIDTH_A   = 4,
   parameter int WIDTH_B   = 4,
   parameter int ACC_GUARD = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH_A-1:0]           a,
   input  logic [WIDTH_B-1:0]           b,
   input  logic                         is_signed,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH_A+WIDTH_B-1:0]   out,
`ifdef MUL_ACC_EN
   input  logic                         acc_clr,
   output logic [WIDTH_A+WIDTH_B+ACC_GUARD-1:0] acc_out,
`endif
   output logic                         busy
);

   localparam int PW = WIDTH_A + 2;
   localparam int QW = WIDTH_B + 1;
   localparam int OW = WIDTH_A + WIDTH_B;
   localparam int CW = $clog2(WIDTH_B + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH_B);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (WIDTH_A < 2 || WIDTH_B < 2 || ACC_GUARD < 1) begin : g_bad_param
         $error("seq_booth_mul: WIDTH_A and WIDTH_B must be >= 2, ACC_GUARD >= 1");
      end
   endgenerate

   logic [1:0]       state;
   logic [WIDTH_A:0] m;
   logic [PW-1:0]    p;
   logic [QW-1:0]    q;
   logic             qm1;
   logic [CW-1:0]    count;

   logic [PW-1:0]    m_ext;
   logic [PW-1:0]    sum;
   logic [PW-1:0]    p_nxt;
   logic [QW-1:0]    q_nxt;
   logic             qm1_nxt;
   logic             accept;
   logic             handoff;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid & in_ready;
   assign handoff   = out_valid & out_ready;

   // P carries one bit more than M so that subtracting the most-negative M cannot overflow.
   always_comb begin
      m_ext = {m[WIDTH_A], m};
      case ({q[0], qm1})
         2'b01:   sum = p + m_ext;
         2'b10:   sum = p - m_ext;
         default: sum = p;
      endcase
      {p_nxt, q_nxt, qm1_nxt} = {sum[PW-1], sum, q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         m     <= '0;
         p     <= '0;
         q     <= '0;
         qm1   <= 1'b0;
         count <= '0;
         out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  m     <= {is_signed & a[WIDTH_A-1], a};
                  q     <= {is_signed & b[WIDTH_B-1], b};
                  p     <= '0;
                  qm1   <= 1'b0;
                  count <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               p     <= p_nxt;
               q     <= q_nxt;
               qm1   <= qm1_nxt;
               count <= count + 1'b1;
               // Product fits in OW bits, so the upper bits of {P,Q} are pure sign copies.
               if (count == LAST) begin
                  out   <= {p_nxt[WIDTH_A-2:0], q_nxt};
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MUL_ACC_EN
   localparam int AW = OW + ACC_GUARD;

   logic          sgn;
   logic [AW-1:0] prod_ext;

   assign prod_ext = {{ACC_GUARD{sgn & out[OW-1]}}, out};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sgn <= 1'b0;
      end else if (accept) begin
         sgn <= is_signed;
      end
   end

   // A clear coinciding with a handshake restarts the sum at this product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_out <= '0;
      end else if (handoff) begin
         acc_out <= (acc_clr ? '0 : acc_out) + prod_ext;
      end else if (acc_clr) begin
         acc_out <= '0;
      end
   end
`endif

endmodule
